// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register-file word and select widths, and the
// writeback collector's state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } wb_state_t;

  // Lane index width; a single-lane build still carries a 1-bit index.
  function automatic int unsigned lane_idx_width(input int unsigned threads);
    return (threads > 1) ? $clog2(threads) : 1;
  endfunction

endpackage

// File: rtl/vector_writeback_collector_if.sv
// Bundle of ALU writeback, vector-load lane return, hazard and register-file
// write port signals around the writeback collector.
interface vector_writeback_collector_if #(
  parameter int THREADS = 4
);
  import cpu_types_pkg::*;

  localparam int IDX_W = lane_idx_width(THREADS);

  logic                      alu_valid;
  regbits_t                  alu_wsel;
  logic [THREADS-1:0]        alu_wen;
  word_t [THREADS-1:0]       alu_wdata;

  logic                      ld_start;
  regbits_t                  ld_wsel;
  logic [THREADS-1:0]        ld_mask;
  logic                      ld_ready;

  logic                      lane_valid;
  logic [IDX_W-1:0]          lane_idx;
  word_t                     lane_data;
  logic                      lane_err;

  logic                      pend_valid;
  regbits_t                  pend_sel;

  regbits_t                  rf_wsel;
  logic [THREADS-1:0]        rf_wen;
  word_t [THREADS-1:0]       rf_wdata;

  // master: the pipeline side producing results; slave: the collector.
  modport master (
    output alu_valid, alu_wsel, alu_wen, alu_wdata,
    output ld_start, ld_wsel, ld_mask,
    output lane_valid, lane_idx, lane_data,
    input  ld_ready, lane_err, pend_valid, pend_sel,
    input  rf_wsel, rf_wen, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_wsel, alu_wen, alu_wdata,
    input  ld_start, ld_wsel, ld_mask,
    input  lane_valid, lane_idx, lane_data,
    output ld_ready, lane_err, pend_valid, pend_sel,
    output rf_wsel, rf_wen, rf_wdata
  );

endinterface

// File: rtl/lane_collect_buffer.sv
// Per-lane store for returning vector-load data, with the received-lane mask
// and the "all expected lanes present" compare.
module lane_collect_buffer
  import cpu_types_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int IDX_W   = 2
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                clr_i,
  input  logic                collect_i,
  input  logic                lane_valid_i,
  input  logic [IDX_W-1:0]    lane_idx_i,
  input  word_t               lane_data_i,
  input  logic [THREADS-1:0]  mask_i,
  output logic                accept_o,
  output logic                complete_o,
  output word_t [THREADS-1:0] lanes_o
);

  word_t              store_q [THREADS];
  logic [THREADS-1:0] got_q;
  logic [THREADS-1:0] hit_vec;

  // A lane is taken only if it is expected and has not arrived already.
  genvar gi;
  generate
    for (gi = 0; gi < THREADS; gi++) begin : g_lane
      assign hit_vec[gi] = collect_i && lane_valid_i && (lane_idx_i == IDX_W'(gi))
                           && mask_i[gi] && !got_q[gi];
      assign lanes_o[gi] = store_q[gi];
    end
  endgenerate

  assign accept_o   = |hit_vec;
  assign complete_o = ((got_q | hit_vec) == mask_i);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      got_q <= '0;
      for (int i = 0; i < THREADS; i++) store_q[i] <= '0;
    end else if (clr_i) begin
      got_q <= '0;
    end else begin
      got_q <= got_q | hit_vec;
      for (int i = 0; i < THREADS; i++) begin
        if (hit_vec[i]) store_q[i] <= lane_data_i;
      end
    end
  end

endmodule

// File: rtl/vector_writeback_collector.sv
// Vector register-file write initiator: forwards ALU results, gathers
// vector-load lanes into one vector and commits it as a single masked write.
module vector_writeback_collector
  import cpu_types_pkg::*;
#(
  parameter int THREADS = 4
) (
  input  logic                         clk,
  input  logic                         nRST,
  vector_writeback_collector_if.slave  wb
);

  localparam int IDX_W = lane_idx_width(THREADS);

  wb_state_t           state_q, state_d;
  logic [THREADS-1:0]  mask_q, mask_d;
  regbits_t            wsel_q, wsel_d;
  regbits_t            rf_wsel_q, rf_wsel_d;
  logic [THREADS-1:0]  rf_wen_q, rf_wen_d;
  word_t [THREADS-1:0] rf_wdata_q, rf_wdata_d;
  logic                ld_ready_q, ld_ready_d;
  logic                lane_err_q, lane_err_d;
  logic                pend_valid_q, pend_valid_d;

  logic                buf_clr;
  logic                commit_fire;
  logic                lane_accept;
  logic                lane_complete;
  word_t [THREADS-1:0] lanes;

  lane_collect_buffer #(
    .THREADS (THREADS),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk          (clk),
    .nRST         (nRST),
    .clr_i        (buf_clr),
    .collect_i    (state_q == COLLECT),
    .lane_valid_i (wb.lane_valid),
    .lane_idx_i   (wb.lane_idx),
    .lane_data_i  (wb.lane_data),
    .mask_i       (mask_q),
    .accept_o     (lane_accept),
    .complete_o   (lane_complete),
    .lanes_o      (lanes)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    wsel_d      = wsel_q;
    buf_clr     = 1'b0;
    commit_fire = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wb.ld_start && (wb.ld_mask != '0)) begin
          mask_d  = wb.ld_mask;
          wsel_d  = wb.ld_wsel;
          buf_clr = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (lane_complete) state_d = COMMIT;
      end
      COMMIT: begin
        // The ALU owns the write port whenever it fires; the commit waits.
        if (!wb.alu_valid) begin
          commit_fire = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rf_wsel_d  = rf_wsel_q;
    rf_wen_d   = '0;
    rf_wdata_d = rf_wdata_q;
    if (wb.alu_valid) begin
      rf_wsel_d  = wb.alu_wsel;
      rf_wen_d   = wb.alu_wen;
      rf_wdata_d = wb.alu_wdata;
    end else if (commit_fire) begin
      rf_wsel_d  = wsel_q;
      rf_wen_d   = mask_q;
      rf_wdata_d = lanes;
    end
    // r0 is hardwired zero: the write slot is consumed but nothing is enabled.
    if (rf_wsel_d == '0) rf_wen_d = '0;

    lane_err_d   = wb.lane_valid && !lane_accept;
    ld_ready_d   = (state_d == IDLE);
    pend_valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      wsel_q       <= '0;
      rf_wsel_q    <= '0;
      rf_wen_q     <= '0;
      rf_wdata_q   <= '0;
      ld_ready_q   <= 1'b1;
      lane_err_q   <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      wsel_q       <= wsel_d;
      rf_wsel_q    <= rf_wsel_d;
      rf_wen_q     <= rf_wen_d;
      rf_wdata_q   <= rf_wdata_d;
      ld_ready_q   <= ld_ready_d;
      lane_err_q   <= lane_err_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign wb.ld_ready   = ld_ready_q;
  assign wb.lane_err   = lane_err_q;
  assign wb.pend_valid = pend_valid_q;
  assign wb.pend_sel   = wsel_q;
  assign wb.rf_wsel    = rf_wsel_q;
  assign wb.rf_wen     = rf_wen_q;
  assign wb.rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_vector_writeback_collector.sv
// Directed bench for vector_writeback_collector: ALU path, out-of-order load
// gather, commit/ALU collision, lane errors, r0 suppression and async reset.
module tb_vector_writeback_collector;
  import cpu_types_pkg::*;

  logic clk;
  logic nRST;
  int   checks   = 0;
  int   failures = 0;

  vector_writeback_collector_if #(.THREADS(4)) wb ();

  vector_writeback_collector #(.THREADS(4)) dut (
    .clk  (clk),
    .nRST (nRST),
    .wb   (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wb.alu_valid  = 1'b0;
    wb.alu_wsel   = '0;
    wb.alu_wen    = '0;
    wb.alu_wdata  = '0;
    wb.ld_start   = 1'b0;
    wb.ld_wsel    = '0;
    wb.ld_mask    = '0;
    wb.lane_valid = 1'b0;
    wb.lane_idx   = '0;
    wb.lane_data  = '0;
  endtask

  task automatic send_lane(input int idx, input logic [31:0] data);
    wb.lane_valid = 1'b1;
    wb.lane_idx   = 2'(idx);
    wb.lane_data  = data;
    tick();
    wb.lane_valid = 1'b0;
  endtask

  task automatic start_load(input logic [4:0] sel, input logic [3:0] mask);
    wb.ld_start = 1'b1;
    wb.ld_wsel  = sel;
    wb.ld_mask  = mask;
    tick();
    wb.ld_start = 1'b0;
  endtask

  initial begin
    int          ord [4];
    logic [31:0] dat [4];
    ord = '{2, 0, 3, 1};
    dat = '{32'h20, 32'h00, 32'h30, 32'h10};

    idle_inputs();
    nRST = 1'b0;
    tick();
    tick();
    chk("reset_ld_ready",   wb.ld_ready,   1);
    chk("reset_rf_wen",     wb.rf_wen,     0);
    chk("reset_pend_valid", wb.pend_valid, 0);
    chk("reset_lane_err",   wb.lane_err,   0);
    $display("txn reset: ld_ready=%0b rf_wen=%b", wb.ld_ready, wb.rf_wen);
    nRST = 1'b1;
    tick();

    // ALU write goes straight through, one cycle later, held one cycle.
    wb.alu_valid = 1'b1;
    wb.alu_wsel  = 5'd5;
    wb.alu_wen   = 4'b1010;
    wb.alu_wdata = {32'hA, 32'hB, 32'hC, 32'hD};
    tick();
    wb.alu_valid = 1'b0;
    chk("alu_wsel",  wb.rf_wsel,  5);
    chk("alu_wen",   wb.rf_wen,   4'b1010);
    chk("alu_wdata", wb.rf_wdata, {32'hA, 32'hB, 32'hC, 32'hD});
    $display("txn alu: rf_wsel=%0d rf_wen=%b", wb.rf_wsel, wb.rf_wen);
    tick();
    chk("alu_wen_one_cycle", wb.rf_wen, 0);

    // Mask of zero is not a load.
    start_load(5'd9, 4'b0000);
    chk("zero_mask_ready", wb.ld_ready,   1);
    chk("zero_mask_pend",  wb.pend_valid, 0);
    $display("txn ld_start mask=0: ld_ready=%0b", wb.ld_ready);

    // A lane in IDLE is dropped.
    send_lane(0, 32'h55);
    chk("idle_lane_err", wb.lane_err, 1);
    $display("txn idle lane: lane_err=%0b", wb.lane_err);
    tick();
    chk("idle_lane_err_pulse", wb.lane_err, 0);

    // Out-of-order gather into r7.
    start_load(5'd7, 4'b1111);
    chk("ooo_ld_ready", wb.ld_ready,   0);
    chk("ooo_pend",     wb.pend_valid, 1);
    for (int i = 0; i < 4; i++) begin
      send_lane(ord[i], dat[i]);
      chk("ooo_pend_sel", wb.pend_sel, 7);
      chk("ooo_no_write", wb.rf_wen,   0);
      chk("ooo_no_err",   wb.lane_err, 0);
      $display("txn lane %0d data=%0h pend_sel=%0d", ord[i], dat[i], wb.pend_sel);
    end
    tick();
    chk("ooo_wsel",  wb.rf_wsel,  7);
    chk("ooo_wen",   wb.rf_wen,   4'b1111);
    chk("ooo_wdata", wb.rf_wdata, {32'h30, 32'h20, 32'h10, 32'h00});
    chk("ooo_pend_clear", wb.pend_valid, 0);
    chk("ooo_ready_back", wb.ld_ready,   1);
    $display("txn commit: rf_wsel=%0d rf_wen=%b rf_wdata=%0h", wb.rf_wsel, wb.rf_wen, wb.rf_wdata);

    // ALU collides with the commit cycle and wins.
    start_load(5'd7, 4'b0001);
    send_lane(0, 32'h77);
    wb.alu_valid = 1'b1;
    wb.alu_wsel  = 5'd3;
    wb.alu_wen   = 4'b1111;
    wb.alu_wdata = {32'h4, 32'h3, 32'h2, 32'h1};
    tick();
    wb.alu_valid = 1'b0;
    chk("coll_alu_wsel", wb.rf_wsel,    3);
    chk("coll_alu_wen",  wb.rf_wen,     4'b1111);
    chk("coll_pend",     wb.pend_valid, 1);
    $display("txn collision alu: rf_wsel=%0d", wb.rf_wsel);
    tick();
    chk("coll_ld_wsel",  wb.rf_wsel,       7);
    chk("coll_ld_wen",   wb.rf_wen,        4'b0001);
    chk("coll_ld_data",  wb.rf_wdata[0],   32'h77);
    chk("coll_pend_clr", wb.pend_valid,    0);
    $display("txn collision load: rf_wsel=%0d rf_wen=%b", wb.rf_wsel, wb.rf_wen);

    // Error handling with mask 0011.
    start_load(5'd9, 4'b0011);
    send_lane(2, 32'hDEAD);
    chk("err_out_of_mask", wb.lane_err, 1);
    tick();
    chk("err_pulse_end", wb.lane_err, 0);
    send_lane(0, 32'h100);
    chk("err_lane0_ok", wb.lane_err, 0);
    send_lane(0, 32'hBAD);
    chk("err_duplicate", wb.lane_err, 1);
    start_load(5'd12, 4'b1111);
    chk("err_start_ignored_ready", wb.ld_ready, 0);
    chk("err_start_ignored_sel",   wb.pend_sel, 9);
    $display("txn errors: ld_ready=%0b pend_sel=%0d", wb.ld_ready, wb.pend_sel);
    send_lane(1, 32'h101);
    chk("err_not_commit_yet", wb.rf_wen, 0);
    tick();
    chk("err_commit_wsel",  wb.rf_wsel,     9);
    chk("err_commit_wen",   wb.rf_wen,      4'b0011);
    chk("err_commit_lane0", wb.rf_wdata[0], 32'h100);
    chk("err_commit_lane1", wb.rf_wdata[1], 32'h101);
    $display("txn err commit: rf_wen=%b lane0=%0h", wb.rf_wen, wb.rf_wdata[0]);

    // r0 load: consumes a commit slot but enables nothing.
    start_load(5'd0, 4'b0001);
    chk("r0_pend", wb.pend_valid, 1);
    send_lane(0, 32'h99);
    tick();
    chk("r0_wen",        wb.rf_wen,     0);
    chk("r0_pend_clear", wb.pend_valid, 0);
    chk("r0_ready",      wb.ld_ready,   1);
    $display("txn r0 load: rf_wen=%b pend_valid=%0b", wb.rf_wen, wb.pend_valid);

    wb.alu_valid = 1'b1;
    wb.alu_wsel  = 5'd0;
    wb.alu_wen   = 4'b1111;
    tick();
    wb.alu_valid = 1'b0;
    chk("r0_alu_wen", wb.rf_wen, 0);

    // Asynchronous reset in the middle of a collection.
    start_load(5'd4, 4'b0011);
    send_lane(0, 32'h44);
    wb.lane_valid = 1'b1;
    wb.lane_idx   = 2'd1;
    wb.lane_data  = 32'h45;
    #2;
    nRST = 1'b0;
    #1;
    chk("mid_reset_ready", wb.ld_ready,   1);
    chk("mid_reset_pend",  wb.pend_valid, 0);
    chk("mid_reset_wen",   wb.rf_wen,     0);
    chk("mid_reset_err",   wb.lane_err,   0);
    $display("txn mid reset: ld_ready=%0b pend_valid=%0b", wb.ld_ready, wb.pend_valid);
    tick();
    nRST = 1'b1;
    tick();
    wb.lane_valid = 1'b0;
    chk("post_reset_lane_err", wb.lane_err, 1);
    tick();
    chk("post_reset_no_write", wb.rf_wen,     0);
    chk("post_reset_no_pend",  wb.pend_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
